uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: UART_TX_PARAM

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the payload bits per frame (legal range 5..9).
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 6, meaning the width of the PRESCALE input.

Interface
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 P_DATA  input  DATA_WIDTH  SHALL be the parallel payload, sampled when a frame is accepted.
REQ-006 DATA_VALID  input  1  SHALL be the payload-valid strobe.
REQ-007 PAR_EN  input  1  SHALL enable the parity bit (1 = parity bit inserted).
REQ-008 PAR_TYP  input  1  SHALL select parity type (0 = even, 1 = odd).
REQ-009 STOP_BITS  input  1  SHALL select the stop-bit count (0 = one stop bit, 1 = two stop bits).
REQ-010 PRESCALE  input  PRESCALE_WIDTH  SHALL give the CLK cycles per serial bit.
REQ-011 S_DATA  output  1  SHALL be the registered serial line output.
REQ-012 BUSY  output  1  SHALL be the registered busy flag, high while a frame is in flight.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE, S_DATA SHALL be 1 and BUSY SHALL be 0.
REQ-015 A frame SHALL be accepted only at a rising edge where the state is IDLE and DATA_VALID=1.
REQ-016 At acceptance, P_DATA, PAR_EN, PAR_TYP, STOP_BITS and PRESCALE SHALL be latched; later input changes SHALL NOT affect the frame in flight.
REQ-017 DATA_VALID SHALL be ignored in every state other than IDLE; there SHALL be no queueing.
REQ-018 From the accepting edge, S_DATA SHALL be 0 (start bit) and BUSY SHALL be 1, with zero added latency.
REQ-019 Bit order SHALL be: start (0), payload LSB first, parity (only if PAR_EN=1), then 1 or 2 stop bits (1).
REQ-020 Each bit SHALL be held for exactly PRESCALE cycles; PRESCALE=0 SHALL be treated as 1.
REQ-021 The parity bit SHALL be the XOR of the latched payload, inverted when PAR_TYP=1.
REQ-022 BUSY duration in cycles SHALL be (2 + DATA_WIDTH + PAR_EN + STOP_BITS) * max(PRESCALE,1).
REQ-023 At the edge ending the last stop bit, the state SHALL return to IDLE with S_DATA=1 and BUSY=0.
REQ-024 DATA_VALID sampled at the edge ending the last stop bit SHALL be ignored, so consecutive frames are separated by at least one idle cycle.
REQ-025 The bit counter SHALL count payload bits 0..DATA_WIDTH-1 and the prescale counter 0..PRESCALE-1; both SHALL clear on every state change and in IDLE.

Reset
REQ-026 RST=0 SHALL force, asynchronously and at any time including mid-frame, state=IDLE, S_DATA=1, BUSY=0, and clear all counters and latched registers.
REQ-027 A frame interrupted by reset SHALL be abandoned; the first accept after RST returns high SHALL start a fresh start bit.

Verification
REQ-028 Reset: drive RST low mid-frame -> S_DATA=1 and BUSY=0 immediately, without waiting for a clock edge.
REQ-029 DATA_WIDTH=8, PRESCALE=1, PAR_EN=1, PAR_TYP=0, STOP_BITS=0, P_DATA=0x2B -> S_DATA sequence 0,1,1,0,1,0,1,0,0,0,1 with BUSY high for 11 cycles.
REQ-030 Same stimulus with PAR_TYP=1 -> parity bit=1 and all other bits unchanged.
REQ-031 PAR_EN=0, STOP_BITS=1, PRESCALE=4, P_DATA=0xA5 -> each bit held 4 cycles; sequence 0,1,0,1,0,0,1,0,1,1,1; BUSY high for 44 cycles.
REQ-032 During the 3rd data bit, pulse DATA_VALID with P_DATA=0x29 and toggle PAR_EN/PRESCALE -> the frame in flight is unchanged, and no second frame starts after BUSY falls.
REQ-033 DATA_WIDTH=5 instance, PRESCALE=0, PAR_EN=1, PAR_TYP=0, P_DATA=5'b10011 -> sequence 0,1,1,0,0,1,1,1 with BUSY high for 8 cycles.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Groups the parallel-load handshake and serial outputs of uart_tx_param.
//
// Signals
//   P_DATA     [DATA_WIDTH-1:0]      parallel payload, sampled on acceptance
//   DATA_VALID                       payload-valid strobe
//   PAR_EN                           1 = insert a parity bit
//   PAR_TYP                          parity type (0 = even, 1 = odd)
//   STOP_BITS                        0 = one stop bit, 1 = two stop bits
//   PRESCALE   [PRESCALE_WIDTH-1:0]  clock cycles per serial bit (0 acts as 1)
//   S_DATA                           registered serial line
//   BUSY                             registered frame-in-flight flag
//
// Modports
//   master : the side that loads frames and watches the line (e.g. a bench)
//   slave  : the transmitter itself
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
);
   logic [DATA_WIDTH-1:0]     P_DATA;
   logic                      DATA_VALID;
   logic                      PAR_EN;
   logic                      PAR_TYP;
   logic                      STOP_BITS;
   logic [PRESCALE_WIDTH-1:0] PRESCALE;
   logic                      S_DATA;
   logic                      BUSY;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP_BITS, PRESCALE,
      input  S_DATA, BUSY
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP_BITS, PRESCALE,
      output S_DATA, BUSY
   );
endinterface

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parameterised UART transmitter. A frame is accepted on a rising edge where
// the FSM is idle and DATA_VALID is high; the payload and all frame options
// are latched at that edge, so the frame in flight is immune to later input
// changes. Frame: start(0), payload LSB first, optional parity, 1 or 2 stop(1).
// Each bit lasts max(PRESCALE,1) clock cycles.
//
// Ports
//   CLK   : clock, all state changes on its rising edge
//   RST   : asynchronous active-low reset
//   bus   : uart_tx_param_if.slave (payload/options in, S_DATA/BUSY out)
//
// Parameters
//   DATA_WIDTH     : payload bits per frame (5..9)
//   PRESCALE_WIDTH : width of PRESCALE
// -----------------------------------------------------------------------------
module uart_tx_param #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic             CLK,
   input  logic             RST,
   uart_tx_param_if.slave   bus
);

   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   state_e                    state_q;
   logic [DATA_WIDTH-1:0]     shift_q;      // payload, shifted right per data bit
   logic                      par_bit_q;    // parity bit computed at acceptance
   logic                      par_en_q;
   logic                      stop2_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;      // latched max(PRESCALE,1)
   logic [PRESCALE_WIDTH-1:0] presc_cnt_q;  // 0..presc_q-1 within a bit
   logic [BIT_W-1:0]          bit_cnt_q;    // payload bit index; stop-bit index in ST_STOP
   logic                      s_data_q;
   logic                      busy_q;

   // High on the last cycle of the current serial bit.
   logic bit_end;
   assign bit_end = (presc_cnt_q == presc_q - PRESCALE_WIDTH'(1));

   assign bus.S_DATA = s_data_q;
   assign bus.BUSY   = busy_q;

   // S_DATA/BUSY are written alongside each state transition so they carry the
   // value of the bit being sent from the very edge that enters that bit.
   // NOTE: every register here, including the latched payload, is reset so a
   // frame cut short by reset leaves nothing behind; sequential state uses
   // non-blocking assignments only so all registers update from the same
   // pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         par_bit_q   <= 1'b0;
         par_en_q    <= 1'b0;
         stop2_q     <= 1'b0;
         presc_q     <= '0;
         presc_cnt_q <= '0;
         bit_cnt_q   <= '0;
         s_data_q    <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_cnt_q <= '0;
               bit_cnt_q   <= '0;
               s_data_q    <= 1'b1;
               busy_q      <= 1'b0;
               if (bus.DATA_VALID) begin
                  state_q   <= ST_START;
                  shift_q   <= bus.P_DATA;
                  // Odd parity is the inverted even parity of the payload.
                  par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
                  par_en_q  <= bus.PAR_EN;
                  stop2_q   <= bus.STOP_BITS;
                  presc_q   <= (bus.PRESCALE == '0) ? PRESCALE_WIDTH'(1) : bus.PRESCALE;
                  s_data_q  <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end

            ST_START: begin
               if (!bit_end) begin
                  presc_cnt_q <= presc_cnt_q + PRESCALE_WIDTH'(1);
               end else begin
                  presc_cnt_q <= '0;
                  state_q     <= ST_DATA;
                  s_data_q    <= shift_q[0];
               end
            end

            ST_DATA: begin
               if (!bit_end) begin
                  presc_cnt_q <= presc_cnt_q + PRESCALE_WIDTH'(1);
               end else begin
                  presc_cnt_q <= '0;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
                     if (par_en_q) begin
                        state_q  <= ST_PARITY;
                        s_data_q <= par_bit_q;
                     end else begin
                        state_q  <= ST_STOP;
                        s_data_q <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                     shift_q   <= shift_q >> 1;
                     s_data_q  <= shift_q[1];
                  end
               end
            end

            ST_PARITY: begin
               if (!bit_end) begin
                  presc_cnt_q <= presc_cnt_q + PRESCALE_WIDTH'(1);
               end else begin
                  presc_cnt_q <= '0;
                  state_q     <= ST_STOP;
                  s_data_q    <= 1'b1;
               end
            end

            ST_STOP: begin
               if (!bit_end) begin
                  presc_cnt_q <= presc_cnt_q + PRESCALE_WIDTH'(1);
               end else begin
                  presc_cnt_q <= '0;
                  if (stop2_q && (bit_cnt_q == '0)) begin
                     // Second stop bit: line stays high, stay in ST_STOP.
                     bit_cnt_q <= BIT_W'(1);
                  end else begin
                     // DATA_VALID is not looked at on this edge, which
                     // guarantees one idle cycle between frames.
                     bit_cnt_q <= '0;
                     state_q   <= ST_IDLE;
                     s_data_q  <= 1'b1;
                     busy_q    <= 1'b0;
                  end
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               presc_cnt_q <= '0;
               bit_cnt_q   <= '0;
               s_data_q    <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Directed bench for uart_tx_param: an 8-bit instance (ifa/dut_a) and a 5-bit
// instance (ifb/dut_b) share one clock. Inputs change just after rising edges
// or on falling edges; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx_param_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) ifa ();
   uart_tx_param_if #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) ifb ();

   uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut_a (
      .CLK (clk),
      .RST (rst_n),
      .bus (ifa)
   );

   uart_tx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) dut_b (
      .CLK (clk),
      .RST (rst_n),
      .bus (ifb)
   );

   // Hard stop in case a wait loop ever misbehaves.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Load a frame into the 8-bit instance: accepted at the next rising edge.
   task automatic start_a(input logic [7:0] d, input logic pe, input logic pt,
                          input logic sb, input logic [5:0] ps);
      @(negedge clk);
      ifa.P_DATA     = d;
      ifa.PAR_EN     = pe;
      ifa.PAR_TYP    = pt;
      ifa.STOP_BITS  = sb;
      ifa.PRESCALE   = ps;
      ifa.DATA_VALID = 1'b1;
      @(posedge clk);
      #1 ifa.DATA_VALID = 1'b0;
   endtask

   task automatic start_b(input logic [4:0] d, input logic pe, input logic pt,
                          input logic sb, input logic [5:0] ps);
      @(negedge clk);
      ifb.P_DATA     = d;
      ifb.PAR_EN     = pe;
      ifb.PAR_TYP    = pt;
      ifb.STOP_BITS  = sb;
      ifb.PRESCALE   = ps;
      ifb.DATA_VALID = 1'b1;
      @(posedge clk);
      #1 ifb.DATA_VALID = 1'b0;
   endtask

   // Record S_DATA on each falling edge while BUSY is high; returns the
   // number of busy cycles. Bounded so a stuck BUSY cannot hang the run.
   task automatic capture(input int sel, output logic [0:255] line, output int n);
      logic b;
      n    = 0;
      line = '0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         b = (sel != 0) ? ifb.BUSY : ifa.BUSY;
         if (!b) break;
         line[n] = (sel != 0) ? ifb.S_DATA : ifa.S_DATA;
         n++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++;
      if (ifa.S_DATA !== 1'b1 || ifa.BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL reset_a: S_DATA=%b BUSY=%b want S_DATA=1 BUSY=0", ifa.S_DATA, ifa.BUSY);
      end
      n_vec++;
      if (ifb.S_DATA !== 1'b1 || ifb.BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL reset_b: S_DATA=%b BUSY=%b want S_DATA=1 BUSY=0", ifb.S_DATA, ifb.BUSY);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (ifa.S_DATA !== 1'b1 || ifa.BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: S_DATA=%b BUSY=%b want 1/0", ifa.S_DATA, ifa.BUSY);
      end
   endtask

   // 0x2B, even parity, one stop, PRESCALE=1.
   task automatic test_parity_even();
      logic [0:255] line;
      logic [0:15]  e;
      int n;
      e = 16'b01101010001_00000;
      start_a(8'h2B, 1'b1, 1'b0, 1'b0, 6'd1);
      capture(0, line, n);
      n_vec++;
      if (n !== 11) begin
         n_err++;
         $display("FAIL parity_even busy_cycles: got %0d want 11", n);
      end
      for (int b = 0; b < 11; b++) begin
         n_vec++;
         if (line[b] !== e[b]) begin
            n_err++;
            $display("FAIL parity_even bit%0d: got %b want %b", b, line[b], e[b]);
         end
      end
   endtask

   // Same payload, odd parity: only the parity bit flips.
   task automatic test_parity_odd();
      logic [0:255] line;
      logic [0:15]  e;
      int n;
      e = 16'b01101010011_00000;
      start_a(8'h2B, 1'b1, 1'b1, 1'b0, 6'd1);
      capture(0, line, n);
      n_vec++;
      if (n !== 11) begin
         n_err++;
         $display("FAIL parity_odd busy_cycles: got %0d want 11", n);
      end
      for (int b = 0; b < 11; b++) begin
         n_vec++;
         if (line[b] !== e[b]) begin
            n_err++;
            $display("FAIL parity_odd bit%0d: got %b want %b", b, line[b], e[b]);
         end
      end
   endtask

   // 0xA5, no parity, two stops, PRESCALE=4: every bit held 4 cycles.
   task automatic test_two_stop_prescale();
      logic [0:255] line;
      logic [0:15]  e;
      int n;
      e = 16'b01010010111_00000;
      start_a(8'hA5, 1'b0, 1'b0, 1'b1, 6'd4);
      capture(0, line, n);
      n_vec++;
      if (n !== 44) begin
         n_err++;
         $display("FAIL prescale4 busy_cycles: got %0d want 44", n);
      end
      for (int b = 0; b < 11; b++) begin
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (line[b*4+k] !== e[b]) begin
               n_err++;
               $display("FAIL prescale4 bit%0d cyc%0d: got %b want %b", b, k, line[b*4+k], e[b]);
            end
         end
      end
   endtask

   // Valid pulse plus option changes during the 3rd data bit must not
   // disturb the frame in flight nor queue a second frame.
   task automatic test_ignore_valid();
      logic [0:255] line;
      logic [0:15]  e;
      int n;
      logic seen_busy;
      e = 16'b01010010111_00000;
      start_a(8'hA5, 1'b0, 1'b0, 1'b1, 6'd4);
      fork
         capture(0, line, n);
         begin
            repeat (13) @(negedge clk);
            ifa.P_DATA     = 8'h29;
            ifa.PAR_EN     = 1'b1;
            ifa.PRESCALE   = 6'd2;
            ifa.DATA_VALID = 1'b1;
            @(posedge clk);
            #1 ifa.DATA_VALID = 1'b0;
         end
      join
      n_vec++;
      if (n !== 44) begin
         n_err++;
         $display("FAIL ignore_valid busy_cycles: got %0d want 44", n);
      end
      for (int b = 0; b < 11; b++) begin
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (line[b*4+k] !== e[b]) begin
               n_err++;
               $display("FAIL ignore_valid bit%0d cyc%0d: got %b want %b", b, k, line[b*4+k], e[b]);
            end
         end
      end
      seen_busy = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ifa.BUSY !== 1'b0 || ifa.S_DATA !== 1'b1) seen_busy = 1'b1;
      end
      n_vec++;
      if (seen_busy !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_valid no_second_frame: busy_seen=%b want 0", seen_busy);
      end
      ifa.PAR_EN   = 1'b0;
      ifa.PRESCALE = 6'd1;
   endtask

   // DATA_VALID held high: frames separated by exactly one idle cycle.
   task automatic test_back_to_back();
      logic [0:255] line;
      logic [0:15]  e;
      int n;
      e = 16'b01101010001_00000;
      @(negedge clk);
      ifa.P_DATA     = 8'h2B;
      ifa.PAR_EN     = 1'b1;
      ifa.PAR_TYP    = 1'b0;
      ifa.STOP_BITS  = 1'b0;
      ifa.PRESCALE   = 6'd1;
      ifa.DATA_VALID = 1'b1;
      capture(0, line, n);
      n_vec++;
      if (n !== 11) begin
         n_err++;
         $display("FAIL b2b first busy_cycles: got %0d want 11", n);
      end
      // The falling edge that ended capture had BUSY low: the idle gap.
      capture(0, line, n);
      ifa.DATA_VALID = 1'b0;
      n_vec++;
      if (n !== 11) begin
         n_err++;
         $display("FAIL b2b second busy_cycles: got %0d want 11", n);
      end
      for (int b = 0; b < 11; b++) begin
         n_vec++;
         if (line[b] !== e[b]) begin
            n_err++;
            $display("FAIL b2b second bit%0d: got %b want %b", b, line[b], e[b]);
         end
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (ifa.BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL b2b stop_after_release: BUSY=%b want 0", ifa.BUSY);
      end
   endtask

   // 5-bit instance, PRESCALE=0 acts as 1, even parity.
   task automatic test_narrow();
      logic [0:255] line;
      logic [0:15]  e;
      int n;
      e = 16'b01100111_00000000;
      start_b(5'b10011, 1'b1, 1'b0, 1'b0, 6'd0);
      capture(1, line, n);
      n_vec++;
      if (n !== 8) begin
         n_err++;
         $display("FAIL narrow busy_cycles: got %0d want 8", n);
      end
      for (int b = 0; b < 8; b++) begin
         n_vec++;
         if (line[b] !== e[b]) begin
            n_err++;
            $display("FAIL narrow bit%0d: got %b want %b", b, line[b], e[b]);
         end
      end
   endtask

   // Reset mid-frame acts without a clock edge; next accept starts fresh.
   task automatic test_reset_midframe();
      logic [0:255] line;
      logic [0:15]  e;
      int n;
      e = 16'b0101010101_000000;
      start_a(8'hA5, 1'b0, 1'b0, 1'b1, 6'd4);
      repeat (10) @(negedge clk);
      n_vec++;
      if (ifa.BUSY !== 1'b1 || ifa.S_DATA !== 1'b0) begin
         n_err++;
         $display("FAIL midframe_pre: BUSY=%b S_DATA=%b want 1/0", ifa.BUSY, ifa.S_DATA);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (ifa.S_DATA !== 1'b1 || ifa.BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: S_DATA=%b BUSY=%b want 1/0", ifa.S_DATA, ifa.BUSY);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (ifa.BUSY !== 1'b0 || ifa.S_DATA !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_idle: BUSY=%b S_DATA=%b want 0/1", ifa.BUSY, ifa.S_DATA);
      end
      // 0x55, no parity, one stop, PRESCALE=2.
      start_a(8'h55, 1'b0, 1'b0, 1'b0, 6'd2);
      capture(0, line, n);
      n_vec++;
      if (n !== 20) begin
         n_err++;
         $display("FAIL post_reset_frame busy_cycles: got %0d want 20", n);
      end
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (line[b*2+k] !== e[b]) begin
               n_err++;
               $display("FAIL post_reset_frame bit%0d cyc%0d: got %b want %b", b, k, line[b*2+k], e[b]);
            end
         end
      end
   endtask

   initial begin
      ifa.P_DATA = '0; ifa.DATA_VALID = 1'b0; ifa.PAR_EN = 1'b0;
      ifa.PAR_TYP = 1'b0; ifa.STOP_BITS = 1'b0; ifa.PRESCALE = '0;
      ifb.P_DATA = '0; ifb.DATA_VALID = 1'b0; ifb.PAR_EN = 1'b0;
      ifb.PAR_TYP = 1'b0; ifb.STOP_BITS = 1'b0; ifb.PRESCALE = '0;

      test_reset();
      test_parity_even();
      test_parity_odd();
      test_two_stop_prescale();
      test_ignore_valid();
      test_back_to_back();
      test_narrow();
      test_reset_midframe();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
